// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter time-sharing one 16-bit adder between NREQ
//            requesters; optional overflow flag under ADDER_ARB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic                 add_op,
  input  logic [15:0]          add_out,
`ifdef ADDER_ARB_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data
);

  logic [IDW-1:0] r_rr;
  logic           r_s1_valid;
  logic [IDW-1:0] r_s1_id;

  logic [IDW-1:0] w_win;
  logic           w_found;
  logic [IDW-1:0] w_rr_next;
  logic [15:0]    w_a [NREQ];
  logic [15:0]    w_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i] = req_a[16*i +: 16];
    assign w_b[i] = req_b[16*i +: 16];
  end

  // Search upward from the pointer, wrapping; first requester found wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_found) begin
      gnt[w_win] = 1'b1;
    end
  end

  assign w_rr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Stage 1: capture the winner's operands into the adder input registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      add_op     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_rr       <= '0;
    end else begin
      r_s1_valid <= w_found;
      if (w_found) begin
        add_a   <= w_a[w_win];
        add_b   <= w_b[w_win];
        add_op  <= req_op[w_win];
        r_s1_id <= w_win;
        r_rr    <= w_rr_next;
      end
    end
  end

  // Stage 2: register the adder result tagged with its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        rsp_id   <= r_s1_id;
        rsp_data <= add_out;
      end
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic w_ovf;

  // Signed overflow: result sign differs from A while B's effective sign matched A.
  always_comb begin
    if (add_op) begin
      w_ovf = (add_a[15] != add_b[15]) && (add_out[15] != add_a[15]);
    end else begin
      w_ovf = (add_a[15] == add_b[15]) && (add_out[15] != add_a[15]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (r_s1_valid) begin
      rsp_ovf <= w_ovf;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that time-shares one `adder16b` instance between up to NREQ requesters (PC incrementer, ALU, branch-target unit, address generator). Each cycle it accepts at most one operation, registers its operands into the adder, and returns the registered result one cycle later, tagged with the requester's index. It owns the adder's `in_a`/`in_b`/`op` inputs and sits between the control unit's requesters and the shared adder.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `IDW`, 2: width of requester index; must equal ceil(log2(NREQ))
- `clk` input 1: system clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `req` input NREQ: per-requester request; bit i high = operation i valid
- `req_a` input NREQ*16: operand A of requester i at bits [16i+15:16i]
- `req_b` input NREQ*16: operand B of requester i, same packing
- `req_op` input NREQ: per-requester op; 0 = add, 1 = subtract (A−B)
- `gnt` output NREQ: combinational one-hot grant; transfer on edge where `req[i] & gnt[i]`
- `add_a` output 16: to adder `in_a`, registered
- `add_b` output 16: to adder `in_b`, registered
- `add_op` output 1: to adder `op`, registered
- `add_out` input 16: from adder `out`, combinational
- `rsp_valid` output 1: one-cycle pulse, result available
- `rsp_id` output IDW: index of requester owning the result
- `rsp_data` output 16: registered result

## Operation
- Arbitration: combinational search of `req` starting at pointer `rr`, ascending, wrapping NREQ−1→0; first set bit wins; `gnt` one-hot for winner, all zero if `req` == 0.
- Accept (stage 1): on edge with any grant, latch winner's `req_a`/`req_b`/`req_op` into `add_a`/`add_b`/`add_op`, latch winner index into `s1_id`, set `s1_valid`=1; `rr` ← (winner+1) mod NREQ. No grant: `s1_valid`=0, operand registers and `rr` hold.
- Execute (stage 2): adder evaluates registered operands combinationally; next edge `rsp_data` ← `add_out`, `rsp_id` ← `s1_id`, `rsp_valid` ← `s1_valid`. `rsp_data`/`rsp_id` hold when `s1_valid`=0.
- No backpressure: requester i must consume the response in the cycle `rsp_valid` && `rsp_id`==i.
- Requester keeps `req` and operands stable until it sees `gnt`; deassertion before grant is legal (request withdrawn, nothing issued).
- Arithmetic: 16-bit two's complement, mod 2^16; no saturation; carry discarded.
- Reset (any time, incl. mid-operation): `add_a`=`add_b`=0, `add_op`=0, `s1_valid`=0, `s1_id`=0, `rr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0; in-flight operations dropped, no response issued. `gnt` follows `req` combinationally even during reset but no transfer occurs while `rst_n`=0.

## Timing
- Accept-to-response latency: 2 edges (accept at edge N, `rsp_valid` high in cycle after edge N+1).
- Throughput: one operation per cycle, back-to-back, any mix of requesters.
- `gnt` depends only on `req` and `rr` (no combinational path from operands or `add_out`).
- Fairness: with all NREQ requesting continuously, each granted exactly once per NREQ cycles.
- Single continuous requester: granted every cycle.

## Configuration
- `ADDER_ARB_OVF_EN` defined: adds output `rsp_ovf` (1 bit, reset 0), registered alongside `rsp_data`. Add: set when `add_a[15]`==`add_b[15]` and `add_out[15]`!=`add_a[15]`. Subtract: set when `add_a[15]`!=`add_b[15]` and `add_out[15]`!=`add_a[15]`. Held when `s1_valid`=0.
- Not defined: port absent, no overflow logic; all other behaviour identical.

## Test plan
- Reset then idle: `req`=0 for 10 cycles -> `gnt`=0, `rsp_valid`=0, all outputs 0.
- Single add: req[2] with A=1, B=1, op=0 -> `gnt`=0100 same cycle; two edges later `rsp_valid`=1, `rsp_id`=2, `rsp_data`=2.
- Wrap and subtract: req[0] A=16'h8000 B=32767 op=0 -> 16'hFFFF; then A=16'hFFFF B=16'h8000 op=1 -> 32767; A=1 B=32767 op=0 -> 16'h8000 (with `ADDER_ARB_OVF_EN`, `rsp_ovf`=1 only on last).
- Contention: all four requesting continuously, distinct operands -> grant order 0,1,2,3,0,...; responses in same order, each `rsp_data` matching its requester's A±B, one per cycle.
- Reset mid-flight: accept op at edge N, assert `rst_n`=0 before edge N+1 -> no `rsp_valid`; after release, first grant from requester 0 regardless of prior `rr`.
- Withdrawal: req[1] and req[3] with `rr`=2; drop req[3] before edge -> `gnt`=0010 that cycle and only requester 1 responds.
